// File: rtl/ita_issue_throttle.sv
// Issue throttle: grants push-producing issues only while output FIFO space can be reserved.
// Define ITA_THROTTLE_STATS_EN to add the saturating stall cycle counter output stall_cnt_o.
module ita_issue_throttle #(
  parameter int unsigned FifoDepth   = 14,
  parameter int unsigned PipeLatency = 10
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        drain_req_i,
  input  logic        issue_req_i,
  output logic        issue_gnt_o,
  input  logic        push_i,
  input  logic        pop_i,
  output logic [7:0]  reserved_o,
  output logic        stall_o,
  output logic        drain_done_o,
`ifdef ITA_THROTTLE_STATS_EN
  output logic [31:0] stall_cnt_o,
`endif
  output logic        err_o
);

  localparam logic [7:0] DepthC = 8'(FifoDepth);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [7:0]             reserved_q, reserved_d;
  logic [PipeLatency-1:0] tok_q, tok_d;
  logic                   err_q, err_d;

  logic gnt_s;
  logic tok_out_s;
  logic start_acc_s;
  logic done_s;
  logic pop_err_s;
  logic push_err_s;

  assign gnt_s        = rst_ni & issue_req_i & (state_q == RUN) & (reserved_q < DepthC);
  assign issue_gnt_o  = gnt_s;
  assign stall_o      = rst_ni & (state_q == RUN) & issue_req_i & ~gnt_s;
  assign drain_done_o = rst_ni & done_s;
  assign reserved_o   = reserved_q;
  assign err_o        = err_q;

  // Each grant enters the token line and must emerge exactly when its push is seen.
  assign tok_out_s = tok_q[PipeLatency-1];
  if (PipeLatency == 1) begin : g_tok_single
    assign tok_d = gnt_s;
  end else begin : g_tok_multi
    assign tok_d = {tok_q[PipeLatency-2:0], gnt_s};
  end

  // Pushes are only policed outside IDLE so stragglers from a reset run are ignored.
  assign pop_err_s  = pop_i & (reserved_q == 8'd0);
  assign push_err_s = (state_q != IDLE) & (push_i ^ tok_out_s);

  // Reservation count: grant adds, pop frees, both together cancel; never below zero.
  always_comb begin
    reserved_d = reserved_q;
    if (gnt_s && !pop_i) begin
      reserved_d = reserved_q + 8'd1;
    end else if (pop_i && !gnt_s && (reserved_q != 8'd0)) begin
      reserved_d = reserved_q - 8'd1;
    end else begin
      reserved_d = reserved_q;
    end
  end

  // Run-control FSM next state; drain completes on the cycle the last reservation frees.
  always_comb begin
    state_d     = state_q;
    start_acc_s = 1'b0;
    done_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d     = RUN;
          start_acc_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (drain_req_i) begin
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if ((reserved_d == 8'd0) && !(|tok_q)) begin
          state_d = IDLE;
          done_s  = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A fresh error in the start cycle still sticks; otherwise start wipes the flag.
  assign err_d = (err_q & ~start_acc_s) | pop_err_s | push_err_s;

  // State, reservation, token line and error registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      reserved_q <= 8'd0;
      tok_q      <= {PipeLatency{1'b0}};
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      reserved_q <= reserved_d;
      tok_q      <= tok_d;
      err_q      <= err_d;
    end
  end

`ifdef ITA_THROTTLE_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of stalled request cycles, restarted with each run.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (start_acc_s) begin
      stall_cnt_d = 32'd0;
    end else if (stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ita_issue_throttle.sv
// Bench for ita_issue_throttle: queue-based reference model checked every cycle,
// directed scenarios pinned with hand-computed values, then randomized traffic.
module tb_ita_issue_throttle;
  localparam int DEPTH = 4;
  localparam int LAT   = 10;
  localparam int LOGN  = 8192;

  logic       clk_i = 1'b0;
  logic       rst_ni, start_i, drain_req_i, issue_req_i, push_i, pop_i;
  logic       issue_gnt_o, stall_o, drain_done_o, err_o;
  logic [7:0] reserved_o;
`ifdef ITA_THROTTLE_STATS_EN
  logic [31:0] stall_cnt_o;
`endif

  ita_issue_throttle #(.FifoDepth(DEPTH), .PipeLatency(LAT)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .drain_req_i (drain_req_i),
    .issue_req_i (issue_req_i),
    .issue_gnt_o (issue_gnt_o),
    .push_i      (push_i),
    .pop_i       (pop_i),
    .reserved_o  (reserved_o),
    .stall_o     (stall_o),
    .drain_done_o(drain_done_o),
`ifdef ITA_THROTTLE_STATS_EN
    .stall_cnt_o (stall_cnt_o),
`endif
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit auto_push;

  // Reference model: mode 0 idle, 1 run, 2 drain; due cycles of outstanding pushes.
  int          m_mode;
  int          m_res;
  bit          m_err;
  int          m_flight[$];
  logic [31:0] m_cnt;

  typedef struct {int gnt; int stall; int res; int done; int err;} obs_t;
  obs_t lg_d[LOGN];
  obs_t lg_m[LOGN];

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic pin(string nm, int dv, int mv, int ex);
    chk({nm, "_dut"}, dv, ex);
    chk({nm, "_model"}, mv, ex);
  endtask

  always @(negedge clk_i) begin : cmp
    int e_gnt, e_stall, e_done, nres;
    bit due, newerr, clr;
    if (!rst_ni) begin
      m_mode = 0; m_res = 0; m_err = 1'b0; m_cnt = 32'd0;
      m_flight.delete();
    end else begin
      e_gnt   = (issue_req_i && m_mode == 1 && m_res < DEPTH) ? 1 : 0;
      e_stall = (m_mode == 1 && issue_req_i && e_gnt == 0) ? 1 : 0;
      due     = (m_flight.size() > 0) && (m_flight[0] == cyc);
      newerr  = (pop_i && m_res == 0) || (m_mode != 0 && (push_i != due));
      nres    = m_res;
      if (e_gnt == 1 && !pop_i) nres = m_res + 1;
      else if (e_gnt == 0 && pop_i && m_res > 0) nres = m_res - 1;
      e_done  = (m_mode == 2 && nres == 0 && m_flight.size() == 0) ? 1 : 0;

      chk("gnt", int'(issue_gnt_o), e_gnt);
      chk("stall", int'(stall_o), e_stall);
      chk("reserved", int'(reserved_o), m_res);
      chk("drain_done", int'(drain_done_o), e_done);
      chk("err", int'(err_o), int'(m_err));
`ifdef ITA_THROTTLE_STATS_EN
      chk("stall_cnt", int'(stall_cnt_o), int'(m_cnt));
`endif
      if (cyc < LOGN) begin
        lg_d[cyc] = '{int'(issue_gnt_o), int'(stall_o), int'(reserved_o), int'(drain_done_o), int'(err_o)};
        lg_m[cyc] = '{e_gnt, e_stall, m_res, e_done, int'(m_err)};
      end

      if (due) void'(m_flight.pop_front());
      if (e_gnt == 1) m_flight.push_back(cyc + LAT);
      clr = (m_mode == 0) && start_i;
      if (clr) m_cnt = 32'd0;
      else if (e_stall == 1 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      m_err = (m_err && !clr) || newerr;
      m_res = nres;
      if (m_mode == 0 && start_i) m_mode = 1;
      else if (m_mode == 1 && drain_req_i) m_mode = 2;
      else if (e_done == 1) m_mode = 0;
    end
    cyc++;
  end

  // One cycle of stimulus; ps is xor-ed onto the model-scheduled push when auto_push is on.
  task automatic drive(logic s, logic d, logic r, logic p, logic ps);
    bit due;
    due = auto_push && (m_flight.size() > 0) && (m_flight[0] == cyc);
    start_i     = s;
    drain_req_i = d;
    issue_req_i = r;
    pop_i       = p;
    push_i      = ps ^ due;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int r0, t0, dd, g, g2, x;
    rst_ni = 1'b0; start_i = 1'b0; drain_req_i = 1'b0;
    issue_req_i = 1'b0; push_i = 1'b0; pop_i = 1'b0;
    auto_push = 1'b1;
    @(posedge clk_i);
    #1;
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    rst_ni = 1'b1;
    r0 = cyc;
    drive(0, 0, 0, 0, 0);

    // Fill to depth, hold request, single pop at relative cycle 20, then drain three entries.
    t0 = cyc;
    drive(1, 0, 0, 0, 0);
    for (int k = 1; k <= 25; k++) drive(0, 0, 1, (k == 20), 0);
    for (int k = 26; k <= 35; k++) drive(0, 0, 0, 0, 0);
    drive(0, 1, 1, 1, 0);
    dd = cyc;
    for (int k = 0; k < 3; k++) drive(0, 0, 1, 1, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0);

    // Push exactly PipeLatency after the grant, then drain.
    auto_push = 1'b0;
    drive(1, 0, 0, 0, 0);
    g = cyc;
    drive(0, 0, 1, 0, 0);
    for (int k = 1; k <= 9; k++) drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    drive(0, 1, 0, 1, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);

    // Push one cycle early, then reset with two tokens in flight and late pushes.
    drive(1, 0, 0, 0, 0);
    g2 = cyc;
    drive(0, 0, 1, 0, 0);
    for (int k = 1; k <= 8; k++) drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 1, 1, 0);
    drive(0, 0, 1, 0, 0);
    rst_ni = 1'b0;
    drive(0, 0, 1, 0, 0);
    rst_ni = 1'b1;
    drive(0, 0, 1, 0, 0);
    for (int k = 15; k <= 20; k++) drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);

    // Pop in IDLE raises the error, start clears it.
    x = cyc;
    drive(0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);

    pin("rst_res", lg_d[r0].res, lg_m[r0].res, 0);
    pin("rst_err", lg_d[r0].err, lg_m[r0].err, 0);
    for (int k = 1; k <= 4; k++) pin("fill_gnt", lg_d[t0+k].gnt, lg_m[t0+k].gnt, 1);
    pin("full_gnt", lg_d[t0+5].gnt, lg_m[t0+5].gnt, 0);
    pin("full_stall", lg_d[t0+5].stall, lg_m[t0+5].stall, 1);
    pin("full_res", lg_d[t0+5].res, lg_m[t0+5].res, 4);
    pin("pop_nobypass", lg_d[t0+20].gnt, lg_m[t0+20].gnt, 0);
    pin("pop_res", lg_d[t0+21].res, lg_m[t0+21].res, 3);
    pin("pop_gnt", lg_d[t0+21].gnt, lg_m[t0+21].gnt, 1);
    pin("refill_res", lg_d[t0+22].res, lg_m[t0+22].res, 4);
    pin("refill_stall", lg_d[t0+22].stall, lg_m[t0+22].stall, 1);
    pin("fill_err", lg_d[t0+35].err, lg_m[t0+35].err, 0);
    pin("drain_res", lg_d[dd].res, lg_m[dd].res, 3);
    pin("drain_gnt", lg_d[dd].gnt, lg_m[dd].gnt, 0);
    pin("drain_early", lg_d[dd+1].done, lg_m[dd+1].done, 0);
    pin("drain_done", lg_d[dd+2].done, lg_m[dd+2].done, 1);
    pin("drain_after", lg_d[dd+3].done, lg_m[dd+3].done, 0);
    pin("idle_gnt", lg_d[dd+3].gnt, lg_m[dd+3].gnt, 0);
    pin("idle_res", lg_d[dd+3].res, lg_m[dd+3].res, 0);
    pin("lat_gnt", lg_d[g].gnt, lg_m[g].gnt, 1);
    pin("lat_ok_err", lg_d[g+11].err, lg_m[g+11].err, 0);
    pin("lat_done", lg_d[g+12].done, lg_m[g+12].done, 1);
    pin("lat_ok_err2", lg_d[g+13].err, lg_m[g+13].err, 0);
    pin("early_err0", lg_d[g2+9].err, lg_m[g2+9].err, 0);
    pin("early_err1", lg_d[g2+10].err, lg_m[g2+10].err, 1);
    pin("prerst_res", lg_d[g2+12].res, lg_m[g2+12].res, 1);
    pin("postrst_res", lg_d[g2+14].res, lg_m[g2+14].res, 0);
    pin("postrst_err", lg_d[g2+14].err, lg_m[g2+14].err, 0);
    pin("postrst_gnt", lg_d[g2+14].gnt, lg_m[g2+14].gnt, 0);
    pin("late_push_err", lg_d[g2+23].err, lg_m[g2+23].err, 0);
    pin("idle_pop_err", lg_d[x+1].err, lg_m[x+1].err, 1);
    pin("start_clr_err", lg_d[x+2].err, lg_m[x+2].err, 0);

    // Randomized traffic with rare resets and rare push misalignment.
    auto_push = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      rst_ni = ($urandom_range(0, 199) != 0);
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 24) == 0),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 149) == 0));
    end
    rst_ni = 1'b1;
    drive(0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ita_issue_throttle.md
ITA_ISSUE_THROTTLE -- requirements
Module: ita_issue_throttle

Interface
REQ-001: Parameter FifoDepth, default 14, output FIFO capacity in entries; SHALL be 2..255.
REQ-002: Parameter PipeLatency, default 10, cycles from issue grant to matching FIFO push; SHALL be >= 1.
REQ-003: Port clk_i  input  1  the only clock; all state changes on its rising edge.
REQ-004: Port rst_ni  input  1  synchronous active-low reset, sampled on rising clk_i.
REQ-005: Port start_i  input  1  one-cycle pulse; begin a run.
REQ-006: Port drain_req_i  input  1  one-cycle pulse; stop granting and drain.
REQ-007: Port issue_req_i  input  1  controller requests to issue a push-producing (last-inner-tile) calculation.
REQ-008: Port issue_gnt_o  output  1  issue allowed this cycle (combinational).
REQ-009: Port push_i  input  1  FIFO push observed.
REQ-010: Port pop_i  input  1  FIFO pop observed.
REQ-011: Port reserved_o  output  8  in-flight issues plus FIFO-resident entries.
REQ-012: Port stall_o  output  1  request blocked while running.
REQ-013: Port drain_done_o  output  1  one-cycle pulse when drain completes.
REQ-014: Port err_o  output  1  sticky protocol error.

Function
REQ-015: FSM states IDLE, RUN, DRAIN; IDLE->RUN on start_i; RUN->DRAIN on drain_req_i; DRAIN->IDLE when reserved==0, asserting drain_done_o for that transition cycle only.
REQ-016: start_i outside IDLE and drain_req_i outside RUN SHALL be ignored; start_i also clears err_o.
REQ-017: issue_gnt_o = issue_req_i AND state==RUN AND registered reserved < FifoDepth; no same-cycle pop bypass.
REQ-018: reserved SHALL increment on grant, decrement on pop_i, stay unchanged on simultaneous grant and pop.
REQ-019: pop_i with reserved==0 SHALL leave reserved at 0 and set err_o.
REQ-020: A PipeLatency-deep token shift line SHALL record each grant; push_i when the emerging token is 0, or a token emerging without push_i, SHALL set err_o.
REQ-021: stall_o = state==RUN AND issue_req_i AND NOT issue_gnt_o.
REQ-022: DRAIN SHALL keep issue_gnt_o low, keep tracking pushes and pops, and not complete while any token remains in the shift line.

Reset
REQ-023: Reset SHALL force state IDLE, reserved 0, shift line 0, err_o 0, drain_done_o 0, issue_gnt_o 0, stall_o 0.
REQ-024: Reset mid-run SHALL discard all in-flight tokens without flagging err_o.

Configuration
REQ-025: With macro ITA_THROTTLE_STATS_EN defined, a 32-bit output stall_cnt_o SHALL count stall_o cycles, saturate at all-ones, clear on reset and start_i.
REQ-026: Without ITA_THROTTLE_STATS_EN, stall_cnt_o and its counter SHALL not exist; all other behaviour unchanged.

Verification
REQ-027: FifoDepth=4, start, issue_req_i held high, no pops -> exactly 4 grants in cycles 1-4, then stall_o high, reserved_o=4.
REQ-028: Same, one pop_i at cycle 20 -> reserved_o 3 at cycle 21, one grant at cycle 21, reserved_o back to 4.
REQ-029: PipeLatency=10, grant at cycle 5, push_i at cycle 15 -> err_o stays 0; push_i instead at cycle 14 -> err_o=1 from cycle 15.
REQ-030: Drain with reserved=3, three pops on cycles 30-32 -> drain_done_o single pulse at cycle 32, IDLE at 33, no grants after drain_req_i.
REQ-031: Reset asserted with reserved=2 and 2 tokens in flight -> next cycle all outputs 0, late push_i ignored, err_o stays 0.
REQ-032: ITA_THROTTLE_STATS_EN defined, 7 stall cycles then start_i in IDLE -> stall_cnt_o=7, then 0.
